// File: rtl/sram_req_responder.sv
// On-chip single-port array standing in for the external SRAM behind the rd_0/wr_0 request channel.
// Optional power-up clear sweep is enabled by defining SRAM_RESP_INIT_CLEAR_EN.
module sram_req_responder #(
  parameter int DATA_WIDTH      = 72,
  parameter int SRAM_ADDR_WIDTH = 24,
  parameter int MEM_ADDR_WIDTH  = 10,
  parameter int RD_LATENCY      = 3,
  parameter int RDQ_DEPTH_BITS  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rd_0_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] rd_0_addr,
  output logic                       rd_0_ack,
  output logic                       rd_0_vld,
  output logic [DATA_WIDTH-1:0]      rd_0_data,
  input  logic                       wr_0_req,
  input  logic [SRAM_ADDR_WIDTH-1:0] wr_0_addr,
  input  logic [DATA_WIDTH-1:0]      wr_0_data,
  output logic                       wr_0_ack,
  output logic                       rdq_nearly_full,
  output logic                       rd_overflow,
  output logic                       init_done
);
  localparam int DEPTH     = 1 << RDQ_DEPTH_BITS;
  localparam int MEM_WORDS = 1 << MEM_ADDR_WIDTH;
  localparam logic [RDQ_DEPTH_BITS:0] Q_FULL = {1'b1, {RDQ_DEPTH_BITS{1'b0}}};
  localparam logic [RDQ_DEPTH_BITS:0] Q_NEAR = {1'b0, {RDQ_DEPTH_BITS{1'b1}}};

  typedef logic [MEM_ADDR_WIDTH-1:0] idx_t;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  idx_t                      rdq_q [DEPTH];
  idx_t                      rdq_d [DEPTH];
  logic [RDQ_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [RDQ_DEPTH_BITS:0]   cnt_q, cnt_d;
  logic                      ovf_q, ovf_d, nfull_q, nfull_d, wr_ack_q, wr_ack_d;
  logic [RD_LATENCY:1]                 vld_pipe_q, vld_pipe_d;
  logic [RD_LATENCY:1][DATA_WIDTH-1:0] data_pipe_q, data_pipe_d;

  logic                  init_done_q;
  logic                  clr_we;
  idx_t                  clr_idx;
  logic                  mem_we;
  idx_t                  mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  wr_go, rd_in, rd_issue, pop, push, drop, push_ok;
  idx_t                  issue_idx;

  // Only the low address bits select a word; the rest alias by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_0_addr[SRAM_ADDR_WIDTH-1:MEM_ADDR_WIDTH],
                              wr_0_addr[SRAM_ADDR_WIDTH-1:MEM_ADDR_WIDTH]};

`ifdef SRAM_RESP_INIT_CLEAR_EN
  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_READY} state_t;
  state_t state_q, state_d;
  idx_t   clr_q, clr_d;
  logic   init_done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      clr_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_d       = clr_q;
    init_done_d = init_done_q;
    clr_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_CLEAR;
        clr_d   = '0;
      end
      S_CLEAR: begin
        clr_we = 1'b1;
        clr_d  = clr_q + 1'b1;
        if (clr_q == '1) begin
          state_d     = S_READY;
          init_done_d = 1'b1;
        end
      end
      S_READY: ;
      default: state_d = S_IDLE;
    endcase
  end
  assign clr_idx = clr_q;
`else
  always_ff @(posedge clk) begin
    if (reset) init_done_q <= 1'b1;
  end
  assign clr_we  = 1'b0;
  assign clr_idx = '0;
`endif

  // Array port: write beats queue head beats a bypassing new read.
  always_comb begin
    wr_go     = init_done_q && wr_0_req;
    rd_in     = init_done_q && rd_0_req;
    pop       = 1'b0;
    push      = 1'b0;
    rd_issue  = 1'b0;
    issue_idx = rdq_q[rd_ptr_q];
    if (wr_go) begin
      push = rd_in;
    end else if (cnt_q != '0) begin
      pop      = 1'b1;
      rd_issue = 1'b1;
      push     = rd_in;
    end else if (rd_in) begin
      rd_issue  = 1'b1;
      issue_idx = rd_0_addr[MEM_ADDR_WIDTH-1:0];
    end
    drop    = push && (cnt_q == Q_FULL) && !pop;
    push_ok = push && !drop;

    rdq_d    = rdq_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      rdq_d[wr_ptr_q] = rd_0_addr[MEM_ADDR_WIDTH-1:0];
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    ovf_d    = ovf_q | drop;
    nfull_d  = (cnt_d >= Q_NEAR);
    wr_ack_d = wr_go;

    mem_we    = 1'b0;
    mem_waddr = wr_0_addr[MEM_ADDR_WIDTH-1:0];
    mem_wdata = wr_0_data;
    if (clr_we) begin
      mem_we    = !reset;
      mem_waddr = clr_idx;
      mem_wdata = '0;
    end else if (wr_go) begin
      mem_we = !reset;
    end

    // Each stage captures only when a read passes, so the last stage holds between pulses.
    vld_pipe_d    = '0;
    data_pipe_d   = data_pipe_q;
    vld_pipe_d[1] = rd_issue;
    if (rd_issue) data_pipe_d[1] = mem[issue_idx];
    for (int k = 2; k <= RD_LATENCY; k++) begin
      vld_pipe_d[k] = vld_pipe_q[k-1];
      if (vld_pipe_q[k-1]) data_pipe_d[k] = data_pipe_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    rdq_q <= rdq_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      nfull_q     <= 1'b0;
      wr_ack_q    <= 1'b0;
      vld_pipe_q  <= '0;
      data_pipe_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      nfull_q     <= nfull_d;
      wr_ack_q    <= wr_ack_d;
      vld_pipe_q  <= vld_pipe_d;
      data_pipe_q <= data_pipe_d;
    end
  end

  assign rd_0_ack        = vld_pipe_q[1];
  assign rd_0_vld        = vld_pipe_q[RD_LATENCY];
  assign rd_0_data       = data_pipe_q[RD_LATENCY];
  assign wr_0_ack        = wr_ack_q;
  assign rdq_nearly_full = nfull_q;
  assign rd_overflow     = ovf_q;
  assign init_done       = init_done_q;
endmodule

// File: tb/tb_sram_req_responder.sv
// Randomized plus directed bench for sram_req_responder; a per-cycle transaction model predicts
// acks, read data, queue flags and overflow from the request stream.
module tb_sram_req_responder;
  localparam int DW = 72;
  localparam int AW = 24;
  localparam int MW = 10;
  localparam int L  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_0_req, wr_0_req;
  logic [AW-1:0] rd_0_addr, wr_0_addr;
  logic [DW-1:0] wr_0_data, rd_0_data;
  logic          rd_0_ack, rd_0_vld, wr_0_ack, rdq_nearly_full, rd_overflow, init_done;

  always #5 clk = ~clk;

  sram_req_responder #(
    .DATA_WIDTH(DW), .SRAM_ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MW),
    .RD_LATENCY(L), .RDQ_DEPTH_BITS(2)
  ) dut (
    .clk(clk), .reset(reset),
    .rd_0_req(rd_0_req), .rd_0_addr(rd_0_addr), .rd_0_ack(rd_0_ack),
    .rd_0_vld(rd_0_vld), .rd_0_data(rd_0_data),
    .wr_0_req(wr_0_req), .wr_0_addr(wr_0_addr), .wr_0_data(wr_0_data),
    .wr_0_ack(wr_0_ack), .rdq_nearly_full(rdq_nearly_full),
    .rd_overflow(rd_overflow), .init_done(init_done)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: word store, pending-read FIFO, expected events keyed by cycle.
  logic [DW-1:0] mmem [int];
  int            pend [$];
  bit            e_wack [int];
  bit            e_rack [int];
  logic [DW-1:0] e_vld [int];
  logic [DW-1:0] last_data = '0;
  bit            m_ovf = 0;
  bit            m_nf = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic issue(input int idx);
    e_rack[cyc+1] = 1;
    e_vld[cyc+L]  = mmem.exists(idx) ? mmem[idx] : 'x;
  endtask

  task automatic enqueue(input int idx);
    if (pend.size() < 4) pend.push_back(idx);
    else m_ovf = 1;
  endtask

  task automatic check_outputs();
    check("wr_0_ack", {71'd0, wr_0_ack}, {71'd0, e_wack.exists(cyc)});
    check("rd_0_ack", {71'd0, rd_0_ack}, {71'd0, e_rack.exists(cyc)});
    check("rd_0_vld", {71'd0, rd_0_vld}, {71'd0, e_vld.exists(cyc)});
    if (e_vld.exists(cyc)) last_data = e_vld[cyc];
    check("rd_0_data", rd_0_data, last_data);
    check("rdq_nearly_full", {71'd0, rdq_nearly_full}, {71'd0, m_nf});
    check("rd_overflow", {71'd0, rd_overflow}, {71'd0, m_ovf});
    check("init_done", {71'd0, init_done}, 72'd1);
    e_wack.delete(cyc);
    e_rack.delete(cyc);
    e_vld.delete(cyc);
  endtask

  task automatic step(input bit w, input int wa, input logic [DW-1:0] wd, input bit r, input int ra);
    int wi, ri;
    wr_0_req  = w;
    wr_0_addr = wa[AW-1:0];
    wr_0_data = wd;
    rd_0_req  = r;
    rd_0_addr = ra[AW-1:0];
    wi = wa & ((1 << MW) - 1);
    ri = ra & ((1 << MW) - 1);
    if (w) begin
      mmem[wi] = wd;
      e_wack[cyc+1] = 1;
      if (r) enqueue(ri);
    end else if (pend.size() > 0) begin
      issue(pend.pop_front());
      if (r) enqueue(ri);
    end else if (r) begin
      issue(ri);
    end
    m_nf = (pend.size() >= 3);
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    wr_0_req = 1'b0;
    rd_0_req = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    reset = 1'b0;
    pend.delete();
    e_wack.delete();
    e_rack.delete();
    e_vld.delete();
    m_ovf     = 0;
    m_nf      = 0;
    last_data = '0;
    check_outputs();
  endtask

  initial begin
    logic [DW-1:0] pat;
    int            wa_r, ra_r;
    bit            w_r, r_r;
    reset     = 1'b1;
    rd_0_req  = 1'b0;
    wr_0_req  = 1'b0;
    rd_0_addr = '0;
    wr_0_addr = '0;
    wr_0_data = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Write then read the same word with an idle gap.
    pat = 72'h0AAAAAAAAAAAAAAA55;
    step(1, 'h10, pat, 0, 0);
    idle(2);
    step(0, 0, '0, 1, 'h10);
    idle(5);

    // Prefill, then six back-to-back reads.
    for (int i = 0; i < 32; i++) step(1, i, DW'(32'h100 + i), 0, 0);
    idle(3);
    for (int i = 0; i < 6; i++) step(0, 0, '0, 1, i);
    idle(8);

    // Sustained writes starve the queue; reads 5 and 6 are dropped.
    for (int i = 0; i < 8; i++)
      step(1, 40 + i, {$urandom, $urandom, $urandom}, (i >= 2), i - 1);
    idle(10);

    // Same-cycle write and read of one index.
    step(1, 'h7, 72'hDEAD, 1, 'h7);
    idle(6);

    // Upper address bits alias.
    step(1, 'h5, 72'hBEEF, 0, 0);
    step(0, 0, '0, 1, 'h400005);
    idle(5);

    // Reset with reads in flight; nothing must come out afterwards.
    step(0, 0, '0, 1, 'h3);
    step(0, 0, '0, 1, 'h4);
    do_reset();
    idle(6);

    // Random traffic over prefilled indices with random alias bits.
    for (int i = 0; i < 400; i++) begin
      w_r  = ($urandom_range(2, 0) == 0);
      r_r  = $urandom_range(1, 0) == 1;
      wa_r = int'(($urandom & 32'h00FF_FC00) | $urandom_range(31, 0));
      ra_r = int'(($urandom & 32'h00FF_FC00) | $urandom_range(31, 0));
      step(w_r, wa_r, {$urandom, $urandom, $urandom}, r_r, ra_r);
    end
    idle(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sram_req_responder.md
Name: sram_req_responder

Overview:
- SRAM-side responder for the single-channel rd_0/wr_0 request interface driven by packet-processing initiators such as the bloom filter shifter.
- Backs requests with an on-chip single-port memory array of 2^MEM_ADDR_WIDTH words.
- Returns acks and read data with fixed latency.
- Stands in for the external SRAM controller in simulation and small builds.

Parameters:
- DATA_WIDTH, 72: memory word and rd/wr data width.
- SRAM_ADDR_WIDTH, 24: request address width.
- MEM_ADDR_WIDTH, 10: implemented array address bits; upper request bits ignored.
- RD_LATENCY, 3: cycles from array read issue to rd_0_vld; legal range 1..8.
- RDQ_DEPTH_BITS, 2: log2 of pending-read queue depth (4 entries).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- rd_0_req  in  1  one read request per cycle asserted
- rd_0_addr  in  SRAM_ADDR_WIDTH  read address, valid with rd_0_req
- rd_0_ack  out  1  pulse: one read issued to array
- rd_0_vld  out  1  pulse: rd_0_data valid
- rd_0_data  out  DATA_WIDTH  read data
- wr_0_req  in  1  one write request per cycle asserted
- wr_0_addr  in  SRAM_ADDR_WIDTH  write address
- wr_0_data  in  DATA_WIDTH  write data
- wr_0_ack  out  1  pulse: write performed
- rdq_nearly_full  out  1  pending-read queue holds >= depth-1 entries
- rd_overflow  out  1  sticky: a read was dropped; cleared only by reset
- init_done  out  1  array ready for requests

Behaviour:
- Reset (clk edge with reset=1):
  - All outputs go to 0, except init_done, which goes to 1 (see Optional Feature).
  - Pending-read queue and read pipeline are flushed; in-flight reads produce no rd_0_vld.
  - Array contents are preserved.
- Requests are single-cycle pulses. Initiators do not wait for ack, so each asserted cycle is a distinct request; back-to-back requests are legal.
- Address mapping: array index = addr[MEM_ADDR_WIDTH-1:0]. Upper bits are ignored, so aliasing is defined behaviour.
- Array port arbitration, one access per cycle, priority order:
  1. Incoming write.
  2. Head of pending-read queue.
  3. Incoming read, issued directly and bypassing the queue only when the queue is empty.
- Read handling:
  - An incoming read that is not issued the same cycle is pushed into the queue.
  - If the queue is full at the push, the read is dropped, rd_overflow is set, and no ack is produced.
  - Queue order is FIFO; reads return strictly in request order.
- Write handling:
  - The write updates the array at the clk edge of the request cycle.
  - wr_0_ack pulses exactly 1 cycle later.
- Read timing:
  - rd_0_ack pulses 1 cycle after array issue.
  - rd_0_vld pulses RD_LATENCY cycles after issue, with rd_0_data = array word at the issue edge.
  - rd_0_data holds its last value when rd_0_vld is low.
- Write priority means a queued read issued after a later write to the same index returns the new data. This is specified behaviour, not a hazard.
- Simultaneous read and write to the same index, with the queue empty:
  - The write is issued and the read is queued.
  - The read is issued next cycle and returns the written data.
- Sustained writes every cycle starve the queue; no fairness is guaranteed.
- rdq_nearly_full is registered and updated every cycle from the post-update occupancy.
- Requests are ignored (no ack, no queue push, no overflow) while init_done=0.

Optional Feature:
- Macro: SRAM_RESP_INIT_CLEAR_EN.
- Defined:
  - After reset deasserts, a clear FSM (IDLE -> CLEAR -> READY) writes 0 to indices 0 .. 2^MEM_ADDR_WIDTH-1, one per cycle.
  - init_done=0 throughout the clear and rises the cycle after the last index is written.
  - Reset during CLEAR restarts the sweep from index 0.
- Undefined:
  - No FSM; init_done=1 from the first cycle after reset.
  - Array contents are undefined until written.

Test Plan:
- Write 0x0AA...55 to addr 0x000010, then read 0x000010 three cycles later -> wr_0_ack at T+1; rd_0_ack at read T+1; rd_0_vld at read T+3 with data 0x0AA...55.
- Six back-to-back reads, addr 0..5, on pre-written words 0x100+i -> six consecutive rd_0_vld pulses returning 0x100..0x105 in order; no overflow.
- Writes on 8 consecutive cycles, with reads to addr 1..6 during cycles 2..7 -> first 4 reads queued, reads 5 and 6 dropped, rd_overflow=1, rdq_nearly_full=1; queued reads drain after writes stop, with 4 rd_0_acks.
- Same-cycle wr addr 0x7 data 0xDEAD and rd addr 0x7 -> wr_0_ack T+1; rd_0_ack T+2; rd_0_vld T+4 data 0xDEAD.
- Read addr 0x400005 after writing 0x5 with 0xBEEF -> returns 0xBEEF (aliasing).
- Reset asserted with 2 reads in pipeline -> no rd_0_vld afterward, outputs 0, rd_overflow cleared; with SRAM_RESP_INIT_CLEAR_EN, init_done rises 1024 cycles after reset and a read of any address returns 0.
